// File: rtl/timer_seq_pkg.sv
// Shared types and widths for the timer sequencer: FSM state encoding and data widths.
package timer_seq_pkg;

    localparam int RELOAD_W = 32;
    localparam int COUNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERROR = 2'd3
    } seq_state_e;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/timer_seq_if.sv
// Reload-command handshake between an upstream producer and the timer sequencer.
interface timer_seq_if;
    import timer_seq_pkg::*;

    logic                cmd_valid;
    logic [RELOAD_W-1:0] cmd_reload;
    logic                cmd_ready;

    modport master (output cmd_valid, output cmd_reload, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_reload, output cmd_ready);

endinterface

// File: rtl/timer_seq_fifo.sv
// Show-ahead synchronous FIFO for queued reload values; flush wins over push and pop.
module timer_seq_fifo
    import timer_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = RELOAD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/timer_sequencer.sv
// Issues queued reload values to a downstream timer one delay at a time.
// Optional watchdog in WAIT enabled by defining TIMER_SEQ_TIMEOUT_EN.
module timer_sequencer
    import timer_seq_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    timer_seq_if.slave          cmd,
    input  logic                flush,
    output logic                tmr_start,
    output logic [RELOAD_W-1:0] tmr_reload,
    input  logic                tmr_done,
    output logic                busy,
    output logic                seq_done,
    output logic [COUNT_W-1:0]  done_count,
    output logic                err
);

    if (DEPTH < 2 || DEPTH > 16 || !is_pow2(DEPTH) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("timer_sequencer: DEPTH must be a power of two in 2..16, TIMEOUT_CYCLES >= 1");
    end

    seq_state_e          state_reg, state_next;
    logic                fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
    logic [RELOAD_W-1:0] fifo_head;
    logic [RELOAD_W-1:0] tmr_reload_reg;
    logic [COUNT_W-1:0]  done_count_reg;
    logic                seq_done_reg, seq_done_next;
    logic                count_inc;
    logic                wd_expired;

`ifdef TIMER_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_reg;
    logic            err_reg;

    assign wd_expired = (state_reg == ST_WAIT) && !tmr_done &&
                        (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

    // Counter restarts whenever the FSM is outside WAIT, so each delay gets a full budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_reg  <= '0;
            err_reg <= 1'b0;
        end else begin
            wd_reg <= (state_reg == ST_WAIT) ? wd_reg + 1'b1 : '0;
            if (wd_expired)
                err_reg <= 1'b1;
            else if (state_reg == ST_ERROR && flush)
                err_reg <= 1'b0;
        end
    end

    assign err           = err_reg;
    assign cmd.cmd_ready = !fifo_full && (state_reg != ST_ERROR);
    assign fifo_flush    = flush || wd_expired;
`else
    assign wd_expired    = 1'b0;
    assign err           = 1'b0;
    assign cmd.cmd_ready = !fifo_full;
    assign fifo_flush    = flush;
`endif

    assign fifo_push = cmd.cmd_valid && cmd.cmd_ready;

    timer_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RELOAD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (cmd.cmd_reload),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // A flush on the same edge as a would-be issue means nothing is left to issue.
    always_comb begin
        state_next    = state_reg;
        fifo_pop      = 1'b0;
        seq_done_next = 1'b0;
        count_inc     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty && !flush) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                fifo_pop   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (tmr_done) begin
                    count_inc = 1'b1;
                    if (!fifo_empty && !flush) begin
                        state_next = ST_ISSUE;
                    end else begin
                        seq_done_next = 1'b1;
                        state_next    = ST_IDLE;
                    end
                end else if (wd_expired) begin
                    state_next = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (flush) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            tmr_reload_reg <= '0;
            seq_done_reg   <= 1'b0;
            done_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            seq_done_reg <= seq_done_next;
            if (state_reg == ST_ISSUE) tmr_reload_reg <= fifo_head;
            if (count_inc) done_count_reg <= done_count_reg + 1'b1;
        end
    end

    assign tmr_start  = (state_reg == ST_ISSUE);
    assign tmr_reload = tmr_start ? fifo_head : tmr_reload_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign seq_done   = seq_done_reg;
    assign done_count = done_count_reg;

endmodule

// File: tb/tb_timer_sequencer.sv
// Randomized and directed bench for timer_sequencer against a queue-based reference model.
// Define TIMER_SEQ_TIMEOUT_EN for both DUT and bench to exercise the watchdog.
module tb_timer_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
`ifdef TIMER_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        tmr_start;
    logic [31:0] tmr_reload;
    logic        tmr_done;
    logic        busy;
    logic        seq_done;
    logic [15:0] done_count;
    logic        err;

    timer_seq_if cmd_if ();

    timer_sequencer #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_if),
        .flush      (flush),
        .tmr_start  (tmr_start),
        .tmr_reload (tmr_reload),
        .tmr_done   (tmr_done),
        .busy       (busy),
        .seq_done   (seq_done),
        .done_count (done_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending commands, what the timer is doing, and the visible results.
    logic [31:0] mq[$];
    bit          m_issuing, m_waiting, m_error, m_seq_done;
    logic [31:0] m_last;
    logic [15:0] m_count;
    int          m_wait_len;

    // Bench-side timer behaviour and observation logs.
    bit          done_en, spur_en;
    int          dly_lo, dly_hi, dly_left;
    logic [31:0] obs_starts[$];
    int          seq_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_issuing  = 0;
        m_waiting  = 0;
        m_error    = 0;
        m_seq_done = 0;
        m_last     = '0;
        m_count    = '0;
        m_wait_len = 0;
        obs_starts.delete();
        seq_cnt    = 0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] d, input bit f, input bit dn);
        bit pre_empty, acc, was_issue, timeout;
        pre_empty  = (mq.size() == 0);
        acc        = v && (mq.size() < DEPTH) && !m_error;
        was_issue  = m_issuing;
        timeout    = 0;
        m_seq_done = 0;
        if (m_issuing) begin
            m_last     = mq[0];
            m_issuing  = 0;
            m_waiting  = 1;
            m_wait_len = 0;
        end else if (m_waiting) begin
            if (dn) begin
                m_count   = m_count + 16'd1;
                m_waiting = 0;
                if (!pre_empty && !f) m_issuing = 1;
                else m_seq_done = 1;
            end else begin
                m_wait_len++;
                if (TMO_EN && m_wait_len == TIMEOUT) begin
                    timeout   = 1;
                    m_waiting = 0;
                    m_error   = 1;
                end
            end
        end else if (m_error) begin
            if (f) m_error = 0;
        end else if (!pre_empty && !f) begin
            m_issuing = 1;
        end
        if (f || timeout) begin
            mq.delete();
        end else begin
            if (was_issue) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
    endtask

    function automatic bit pick_done();
        if (m_issuing) begin
            dly_left = $urandom_range(dly_hi, dly_lo);
            return spur_en && ($urandom_range(0, 3) == 0);
        end else if (m_waiting) begin
            dly_left--;
            return done_en && (dly_left == 0);
        end
        return spur_en && ($urandom_range(0, 3) == 0);
    endfunction

    task automatic compare_all();
        check("tmr_start", {31'd0, tmr_start}, {31'd0, m_issuing});
        check("tmr_reload", tmr_reload, m_issuing ? mq[0] : m_last);
        check("busy", {31'd0, busy}, {31'd0, m_issuing || m_waiting || m_error});
        check("cmd_ready", {31'd0, cmd_if.cmd_ready}, {31'd0, (mq.size() < DEPTH) && !m_error});
        check("seq_done", {31'd0, seq_done}, {31'd0, m_seq_done});
        check("done_count", {16'd0, done_count}, {16'd0, m_count});
        check("err", {31'd0, err}, {31'd0, m_error});
        if (tmr_start) obs_starts.push_back(tmr_reload);
        if (seq_done) seq_cnt++;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic run_cycle(input bit v, input logic [31:0] d, input bit f, input bit dn);
        bit done_now;
        done_now          = pick_done() || dn;
        cmd_if.cmd_valid  = v;
        cmd_if.cmd_reload = d;
        flush             = f;
        tmr_done          = done_now;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step(v, d, f, done_now);
        #1;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_reload = '0;
        flush             = 1'b0;
        tmr_done          = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, 32'd0, 0, 0);
    endtask

    initial begin
        done_en = 0; spur_en = 0; dly_lo = 3; dly_hi = 3; dly_left = 0;

        // Reset values
        do_reset();
        check("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_start", {31'd0, tmr_start}, 32'd0);
        check("rst_reload", tmr_reload, 32'd0);
        check("rst_count", {16'd0, done_count}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_seq_done", {31'd0, seq_done}, 32'd0);

        // Single push: start follows one edge after acceptance
        run_cycle(1, 32'd10, 0, 0);
        run_cycle(0, 32'd0, 0, 0);
        check("first_start", {31'd0, tmr_start}, 32'd1);
        check("first_reload", tmr_reload, 32'd10);
        check("first_busy", {31'd0, busy}, 32'd1);

        // Three delays, done three cycles after each start
        do_reset();
        done_en = 1; dly_lo = 3; dly_hi = 3;
        run_cycle(1, 32'd5, 0, 0);
        run_cycle(1, 32'd7, 0, 0);
        run_cycle(1, 32'd9, 0, 0);
        idle_cycles(20);
        check("seq_starts_n", obs_starts.size(), 32'd3);
        if (obs_starts.size() == 3) begin
            check("seq_start0", obs_starts[0], 32'd5);
            check("seq_start1", obs_starts[1], 32'd7);
            check("seq_start2", obs_starts[2], 32'd9);
        end
        check("seq_done_n", seq_cnt, 32'd1);
        check("seq_count", {16'd0, done_count}, 32'd3);

        // Backpressure: queue fills while the first delay is stuck
        do_reset();
        done_en = 0;
        for (int i = 1; i <= 5; i++) run_cycle(1, i, 0, 0);
        check("full_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
        run_cycle(1, 32'd6, 0, 1);
        check("full_ready_issue", {31'd0, cmd_if.cmd_ready}, 32'd0);
        check("full_start", {31'd0, tmr_start}, 32'd1);
        run_cycle(1, 32'd6, 0, 0);
        check("pop_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        run_cycle(1, 32'd6, 0, 0);
        check("refill_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);

        // Flush during the first WAIT lets that delay finish, nothing else issues
        do_reset();
        done_en = 1; dly_lo = 3; dly_hi = 3;
        run_cycle(1, 32'd11, 0, 0);
        run_cycle(1, 32'd22, 0, 0);
        run_cycle(1, 32'd33, 0, 0);
        run_cycle(0, 32'd0, 1, 0);
        idle_cycles(12);
        check("flush_starts", obs_starts.size(), 32'd1);
        check("flush_count", {16'd0, done_count}, 32'd1);
        check("flush_seq_done", seq_cnt, 32'd1);

        // Reset mid-WAIT, then a late tmr_done
        do_reset();
        done_en = 0;
        run_cycle(1, 32'hFFFF_FFFF, 0, 0);
        run_cycle(0, 32'd0, 0, 0);
        run_cycle(0, 32'd0, 0, 0);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        run_cycle(0, 32'd0, 0, 1);
        run_cycle(0, 32'd0, 0, 0);
        check("late_done_count", {16'd0, done_count}, 32'd0);
        check("late_done_busy", {31'd0, busy}, 32'd0);
        check("late_done_reload", tmr_reload, 32'd0);
        check("late_done_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);

`ifdef TIMER_SEQ_TIMEOUT_EN
        // Watchdog: no tmr_done ever
        do_reset();
        done_en = 0;
        run_cycle(1, 32'd0, 0, 0);
        idle_cycles(12);
        check("wd_err", {31'd0, err}, 32'd1);
        check("wd_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
        check("wd_busy", {31'd0, busy}, 32'd1);
        run_cycle(0, 32'd0, 1, 0);
        check("wd_clr_err", {31'd0, err}, 32'd0);
        check("wd_clr_busy", {31'd0, busy}, 32'd0);
        check("wd_clr_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
`endif

        // Randomized traffic with spurious done pulses and occasional flushes
        do_reset();
        done_en = 1; spur_en = 1; dly_lo = 1; dly_hi = 5;
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] d;
            int sel;
            sel = $urandom_range(0, 7);
            d   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
            run_cycle($urandom_range(0, 1) == 1, d, $urandom_range(0, 29) == 0, 0);
        end
        idle_cycles(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
